imply_stack: RTL



---
 rtl/imply_stack_pkg.sv | 13 +
 rtl/imply_stack.sv | 105 ++++++++++
 2 files changed

// File: rtl/imply_stack_pkg.sv
// Shared definitions for the implication stack: solver sizing constants and the stack entry type.
package imply_stack_pkg;

    localparam int unsigned MAX_VARS          = 4;
    localparam int unsigned MAX_VARS_BITS     = 9;
    localparam int unsigned IMPLY_STACK_DEPTH = MAX_VARS;

    typedef struct packed {
        logic [MAX_VARS_BITS-1:0] var_idx;
        logic                     val;
    } imply_entry_t;

endpackage

// File: rtl/imply_stack.sv
// LIFO of implied variable assignments: pushed by the conflict detector, popped by the
// propagation front end, flushed wholesale on conflict/backtrack.
module imply_stack
    import imply_stack_pkg::*;
#(
    parameter  int unsigned DEPTH = IMPLY_STACK_DEPTH,
    localparam int unsigned IDX_W = MAX_VARS_BITS,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_en,
    input  logic [IDX_W-1:0] push_var_idx,
    input  logic             push_val,
    input  logic             pop_en,
    input  logic             flush,
    output logic             pop_valid,
    output logic [IDX_W-1:0] pop_var_idx,
    output logic             pop_val,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    imply_entry_t     mem_q [DEPTH];
    imply_entry_t     mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_valid_q, pop_valid_d;
    imply_entry_t     pop_entry_q, pop_entry_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             pop_acc, push_acc;
    logic [AW-1:0]    top_idx, free_idx;
    imply_entry_t     push_entry;

    assign push_entry = '{var_idx: push_var_idx, val: push_val};
    assign top_idx    = AW'(count_q - CNT_W'(1));
    assign free_idx   = AW'(count_q);
    assign pop_acc    = pop_en && (count_q != '0);
    // A simultaneous pop frees the top slot, so a push into a full stack still lands.
    assign push_acc   = push_en && ((count_q != CNT_W'(DEPTH)) || pop_acc);

    always_comb begin
        mem_d       = mem_q;
        count_d     = count_q;
        pop_valid_d = 1'b0;
        pop_entry_d = pop_entry_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop_acc) begin
                pop_valid_d = 1'b1;
                pop_entry_d = mem_q[top_idx];
            end
            if (pop_en && !pop_acc) underflow_d = 1'b1;
            if (push_en && !push_acc) overflow_d = 1'b1;
            if (push_acc && pop_acc) begin
                mem_d[top_idx] = push_entry;
            end else if (push_acc) begin
                mem_d[free_idx] = push_entry;
                count_d         = count_q + CNT_W'(1);
            end else if (pop_acc) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_entry_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            pop_entry_q <= pop_entry_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally left unreset; count alone defines which entries are live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign pop_valid   = pop_valid_q;
    assign pop_var_idx = pop_entry_q.var_idx;
    assign pop_val     = pop_entry_q.val;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
